// File: rtl/audio_clock_ctrl.sv
// audio_clock_ctrl: rate-change handshake, sequential divider and bclk/lrclk generator that switches rate only at frame boundaries.
// Optional AUDIO_CLK_MUTE_EN adds mute_in, which freezes the clocks low at the next frame boundary.
module audio_clock_ctrl #(
  parameter int unsigned IN_FREQ = 12288000,
  parameter int unsigned BCLK_PER_FRAME = 64,
  parameter int unsigned DEFAULT_RATE = 48000
) (
  input  logic        clock_in,
  input  logic        reset_n,
`ifdef AUDIO_CLK_MUTE_EN
  input  logic        mute_in,
`endif
  input  logic        rate_req,
  input  logic [31:0] rate_val,
  output logic        rate_ack,
  output logic        busy,
  output logic        error,
  output logic [31:0] lim_out,
  output logic        bclk_out,
  output logic        lrclk_out
);
  localparam int BW = $clog2(BCLK_PER_FRAME);
  localparam logic [47:0] DEF_D = 48'(DEFAULT_RATE) * 48'(2 * BCLK_PER_FRAME);
  localparam logic [31:0] DEF_LIM = 32'(48'(IN_FREQ) / DEF_D - 48'd1);
  localparam logic [BW-1:0] LAST = BW'(BCLK_PER_FRAME - 1);
  localparam logic [BW-1:0] HALF = BW'(BCLK_PER_FRAME / 2);

  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, WAIT_FRAME, ACK} state_t;
  state_t state, state_d;
  logic [31:0] rate_r, cnt, rem, quo, den;
  logic [4:0] step;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [47:0] d;
  logic [32:0] rem_sh;
  logic tick, fall, fb, bad, apply, frozen, fits;

  assign d = 48'(rate_r) * 48'(2 * BCLK_PER_FRAME);
  assign bad = rate_r == 32'd0 || d > 48'(IN_FREQ);
  assign tick = cnt >= lim_out;
  assign fall = tick && bclk_out;
  assign fb = fall && bit_cnt == LAST;
  assign bit_nxt = bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
  assign rem_sh = {rem, quo[31]};
  assign fits = rem_sh >= {1'b0, den};

`ifdef AUDIO_CLK_MUTE_EN
  logic muted;
  assign frozen = muted;
  // a pending limit may also land while the generator is already frozen
  assign apply = state == WAIT_FRAME && (fb || muted);
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) muted <= 1'b0;
    else muted <= mute_in && (muted || fb);
`else
  assign frozen = 1'b0;
  assign apply = state == WAIT_FRAME && fb;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:       state_d = rate_req ? CHECK : IDLE;
      CHECK:      state_d = bad ? ACK : DIVIDE;
      DIVIDE:     state_d = step == 5'd31 ? WAIT_FRAME : DIVIDE;
      WAIT_FRAME: state_d = apply ? ACK : WAIT_FRAME;
      ACK:        state_d = rate_req ? ACK : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      rate_ack <= 1'b0;
      error <= 1'b0;
      rate_r <= '0;
      rem <= '0;
      quo <= '0;
      den <= '0;
      step <= '0;
    end else begin
      busy <= state_d inside {CHECK, DIVIDE, WAIT_FRAME};
      rate_ack <= state_d == ACK;
      if (state == IDLE && rate_req) begin
        rate_r <= rate_val;
        error <= 1'b0;
      end
      if (state == CHECK) begin
        error <= bad;
        rem <= '0;
        quo <= IN_FREQ;
        den <= d[31:0];
        step <= '0;
      end
      // restoring division: dividend bits shift out of quo as quotient bits shift in
      if (state == DIVIDE) begin
        rem <= fits ? 32'(rem_sh - {1'b0, den}) : rem_sh[31:0];
        quo <= {quo[30:0], fits};
        step <= step + 5'd1;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lim_out <= DEF_LIM;
      cnt <= '0;
      bit_cnt <= '0;
      bclk_out <= 1'b0;
      lrclk_out <= 1'b0;
    end else begin
      if (!frozen) begin
        cnt <= tick ? '0 : cnt + 32'd1;
        bclk_out <= bclk_out ^ tick;
        if (fall) begin
          bit_cnt <= bit_nxt;
          lrclk_out <= bit_nxt == HALF ? 1'b1 : bit_nxt == '0 ? 1'b0 : lrclk_out;
        end
      end
      if (apply) begin
        lim_out <= quo - 32'd1;
        cnt <= '0;
      end
    end
  end
endmodule
